// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator: one bit per cycle, MSB first.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing bit is seen.
module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             diff, dgt, dlt;

    logic bit_a, bit_b, bit_ne;
    logic nxt_diff, nxt_gt, nxt_lt, last;

    // 1-bit compare stage; the first difference wins and is never overwritten
    assign bit_a    = sa[WIDTH-1];
    assign bit_b    = sb[WIDTH-1];
    assign bit_ne   = bit_a ^ bit_b;
    assign nxt_diff = diff | bit_ne;
    assign nxt_gt   = diff ? dgt : (bit_a & ~bit_b);
    assign nxt_lt   = diff ? dlt : (~bit_a & bit_b);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign last = (cnt == '0) || nxt_diff;
`else
    assign last = (cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            diff  <= 1'b0;
            dgt   <= 1'b0;
            dlt   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= CW'(WIDTH - 1);
                        diff  <= 1'b0;
                        dgt   <= 1'b0;
                        dlt   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa   <= sa << 1;
                    sb   <= sb << 1;
                    diff <= nxt_diff;
                    dgt  <= nxt_gt;
                    dlt  <= nxt_lt;
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        eq    <= ~nxt_diff;
                        gt    <= nxt_gt;
                        lt    <= nxt_lt;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl: WIDTH=8 and WIDTH=1 instances, directed vectors.
// Edge index 1 is the edge that samples start; done is expected after edge index <lat>.
module tb_serial_cmp_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       busy8, done8, eq8, gt8, lt8;
    logic       busy1, done1, eq1, gt1, lt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] res;   // {eq,gt,lt}
        int         lat;
        string      name;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    serial_cmp_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
    );

    serial_cmp_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // Monitors: lat counts busy-high cycles; busy rises right after the sampling edge.
    int lat8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!busy8) lat8 = 0;
        else        lat8 = lat8 + 1;
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected_done: got done=1 eq/gt/lt=%b%b%b, want no done", eq8, gt8, lt8);
            end else begin
                e = q8.pop_front();
                if ({eq8, gt8, lt8} !== e.res || lat8 != e.lat) begin
                    errors++;
                    $display("FAIL w8_%s: got eq/gt/lt=%b lat=%0d, want %b lat=%0d",
                             e.name, {eq8, gt8, lt8}, lat8, e.res, e.lat);
                end
            end
        end
    end

    int lat1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!busy1) lat1 = 0;
        else        lat1 = lat1 + 1;
        if (done1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL w1_unexpected_done: got done=1 eq/gt/lt=%b%b%b, want no done", eq1, gt1, lt1);
            end else begin
                e = q1.pop_front();
                if ({eq1, gt1, lt1} !== e.res || lat1 != e.lat) begin
                    errors++;
                    $display("FAIL w1_%s: got eq/gt/lt=%b lat=%0d, want %b lat=%0d",
                             e.name, {eq1, gt1, lt1}, lat1, e.res, e.lat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Wait (bounded) until the monitors have consumed every expectation.
    task automatic drain(input string name);
        int n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (q8.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending results, want 0", name, q8.size() + q1.size());
            q8.delete();
            q1.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic cmp8(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] res,
                        input int lat_early, input string name);
        exp_t e;
        e.res  = res;
        e.lat  = EARLY ? lat_early : 9;
        e.name = name;
        @(posedge clk); #1;
        a8 = va; b8 = vb; start8 = 1'b1;
        q8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
        drain(name);
    endtask

    task automatic cmp1(input logic va, input logic vb, input logic [2:0] res, input string name);
        exp_t e;
        e.res  = res;
        e.lat  = 2;
        e.name = name;
        @(posedge clk); #1;
        a1 = va; b1 = vb; start1 = 1'b1;
        q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
        drain(name);
    endtask

    initial begin
        // Reset held with start high: start must be discarded
        start8 = 1'b1; start1 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; start8 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        chk("reset_outputs_w8", {busy8, done8, eq8, gt8, lt8}, 5'b0);
        chk("reset_outputs_w1", {busy1, done1, eq1, gt1, lt1}, 5'b0);

        cmp8(8'hA5, 8'hA5, 3'b100, 9, "eq_a5");
        chk("busy_low_after_done", busy8, 1'b0);
        chk("eq_held_in_idle", {eq8, gt8, lt8}, 3'b100);
        cmp8(8'h80, 8'h7F, 3'b010, 2, "gt_msb");
        cmp8(8'h01, 8'h02, 3'b001, 8, "lt_bit1");
        cmp8(8'hFF, 8'hFE, 3'b010, 9, "gt_lsb");
        cmp8(8'h00, 8'hFF, 3'b001, 2, "lt_zero_ff");
        cmp8(8'h00, 8'h00, 3'b100, 9, "eq_zero");
        cmp8(8'hFF, 8'hFF, 3'b100, 9, "eq_ones");

        // start held and operands changed mid-run: only the captured pair counts
        begin
            exp_t e;
            int n = 0;
            e.res = 3'b001; e.lat = EARLY ? 4 : 9; e.name = "hold_start";
            @(posedge clk); #1;
            a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
            q8.push_back(e);
            @(posedge clk); #1;
            a8 = 8'hFF; b8 = 8'h00;
            while (!done8 && n < 20) begin
                @(negedge clk);
                n++;
            end
            start8 = 1'b0;
            chk("hold_start_done_seen", done8, 1'b1);
            repeat (12) @(posedge clk);
            @(negedge clk);
            chk("hold_start_no_restart", busy8, 1'b0);
            drain("hold_start");
        end

        // Reset during RUN cycle 4 aborts without a done pulse
        begin
            int seen = 0;
            @(posedge clk); #1;
            a8 = 8'h33; b8 = 8'h33; start8 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("abort_cleared", {busy8, done8, eq8, gt8, lt8}, 5'b0);
            repeat (12) begin
                @(negedge clk);
                if (done8) seen++;
            end
            chk("abort_no_done", seen, 0);
        end
        cmp8(8'hC3, 8'h3C, 3'b010, 2, "after_abort_gt");

        cmp1(1'b1, 1'b0, 3'b010, "w1_gt");
        cmp1(1'b0, 1'b1, 3'b001, "w1_lt");
        cmp1(1'b1, 1'b1, 3'b100, "w1_eq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
